tx_bus_framer: RTL

- Transmit-side counterpart of the backplane bus receive path.
- On a request, captures header fields, writes a complete frame image into the TX frame buffer, then hands the frame to the TX PHY.
  - Header: DA, SA, FC, MODE, 24-bit ADDR.
  - Payload: fetched from a local source buffer.
- The TX PHY serialises the frame and appends the CRC. This block does not compute CRC.

---
 rtl/tx_bus_framer_if.sv | 40 ++++
 rtl/tx_bus_framer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/tx_bus_framer_if.sv
// Bus bundle between a frame requester, the local source buffer, the TX frame
// buffer and the TX PHY on one side and the transmit framer on the other.
interface tx_bus_framer_if;
   logic [2:0]  rack_id;
   logic [3:0]  slot_id;
   logic        tx_req;
   logic [7:0]  tx_da;
   logic [7:0]  tx_fc;
   logic [7:0]  tx_mode;
   logic [23:0] tx_addr;
   logic [10:0] tx_plen;
   logic        tx_ack;
   logic        len_err;
   logic        src_rden;
   logic [23:0] src_raddr;
   logic [7:0]  src_rdata;
   logic        tx_buf_wren;
   logic [10:0] tx_buf_waddr;
   logic [7:0]  tx_buf_wdata;
   logic        tx_start;
   logic [10:0] tx_len;
   logic        tx_done;
   logic        tx_busy;

   // Framer view: takes requests and source data, drives buffer writes and PHY handoff
   modport slave (
      input  rack_id, slot_id, tx_req, tx_da, tx_fc, tx_mode, tx_addr, tx_plen,
             src_rdata, tx_done,
      output tx_ack, len_err, src_rden, src_raddr, tx_buf_wren, tx_buf_waddr,
             tx_buf_wdata, tx_start, tx_len, tx_busy
   );

   // Environment view: requester, source buffer, frame buffer and PHY
   modport master (
      output rack_id, slot_id, tx_req, tx_da, tx_fc, tx_mode, tx_addr, tx_plen,
             src_rdata, tx_done,
      input  tx_ack, len_err, src_rden, src_raddr, tx_buf_wren, tx_buf_waddr,
             tx_buf_wdata, tx_start, tx_len, tx_busy
   );
endinterface

// File: rtl/tx_bus_framer.sv
// Transmit framer: captures a request, writes the 7-byte header and the payload
// fetched from the source buffer into the TX frame buffer, then hands the frame
// to the TX PHY (which appends the CRC) and waits for it to finish.
module tx_bus_framer #(
   parameter int MAX_PAYLOAD = 1024
) (
   input logic           clk,
   input logic           reset,
   tx_bus_framer_if.slave bus
);

   localparam int HDR_LEN = 7;

   typedef enum logic [2:0] {
      IDLE,
      HDR,
      PAY,
      START,
      WAIT_DONE
   } state_t;

   state_t      r_state;
   state_t      w_nextState;

   logic [2:0]  r_hdrIdx;
   logic [10:0] r_payCnt;
   logic [7:0]  r_da;
   logic [7:0]  r_sa;
   logic [7:0]  r_fc;
   logic [7:0]  r_mode;
   logic [23:0] r_addr;
   logic [10:0] r_plen;
   logic [10:0] r_txLen;
   logic        r_lenErr;
   logic [10:0] r_lastWaddr;
   logic [7:0]  r_lastWdata;
   logic [23:0] r_lastRaddr;

   logic        w_tooLong;
   logic        w_accept;
   logic        w_reject;
   logic        w_lastPay;
   logic [11:0] w_nextRead;
   logic        w_wren;
   logic [10:0] w_waddr;
   logic [7:0]  w_wdata;
   logic        w_rden;
   logic [23:0] w_raddr;

   assign w_tooLong  = {1'b0, bus.tx_plen} > 12'(MAX_PAYLOAD);
   assign w_accept   = (r_state == IDLE) && bus.tx_req && !w_tooLong;
   assign w_reject   = (r_state == IDLE) && bus.tx_req && w_tooLong;
   assign w_lastPay  = (r_payCnt == (r_plen - 11'd1));
   assign w_nextRead = {1'b0, r_payCnt} + 12'd1;

   // State register: reset aborts any frame in flight and returns to IDLE
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // Next-state logic: header, optional payload, PHY kick, then wait for completion
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:      if (w_accept) w_nextState = HDR;
         HDR:       if (r_hdrIdx == 3'd6) w_nextState = (r_plen == 11'd0) ? START : PAY;
         PAY:       if (w_lastPay) w_nextState = START;
         START:     w_nextState = WAIT_DONE;
         WAIT_DONE: if (bus.tx_done) w_nextState = IDLE;
         default:   w_nextState = IDLE;
      endcase
   end

   // Output logic: buffer writes and source reads; addresses and data hold when idle
   always_comb begin
      w_wren  = 1'b0;
      w_waddr = r_lastWaddr;
      w_wdata = r_lastWdata;
      w_rden  = 1'b0;
      w_raddr = r_lastRaddr;
      case (r_state)
         HDR: begin
            w_wren  = 1'b1;
            w_waddr = {8'd0, r_hdrIdx};
            case (r_hdrIdx)
               3'd0:    w_wdata = r_da;
               3'd1:    w_wdata = r_sa;
               3'd2:    w_wdata = r_fc;
               3'd3:    w_wdata = r_mode;
               3'd4:    w_wdata = r_addr[23:16];
               3'd5:    w_wdata = r_addr[15:8];
               default: w_wdata = r_addr[7:0];
            endcase
            if ((r_hdrIdx == 3'd6) && (r_plen != 11'd0)) begin
               w_rden  = 1'b1;
               w_raddr = r_addr;
            end
         end
         PAY: begin
            w_wren  = 1'b1;
            w_waddr = 11'(HDR_LEN) + r_payCnt;
            w_wdata = bus.src_rdata;
            if (w_nextRead < {1'b0, r_plen}) begin
               w_rden  = 1'b1;
               w_raddr = r_addr + {12'd0, w_nextRead};
            end
         end
         default: begin
         end
      endcase
   end

   // Datapath registers: request capture, byte counters, error pulse and held bus values
   always_ff @(posedge clk) begin
      if (reset) begin
         r_hdrIdx    <= '0;
         r_payCnt    <= '0;
         r_da        <= '0;
         r_sa        <= '0;
         r_fc        <= '0;
         r_mode      <= '0;
         r_addr      <= '0;
         r_plen      <= '0;
         r_txLen     <= '0;
         r_lenErr    <= 1'b0;
         r_lastWaddr <= '0;
         r_lastWdata <= '0;
         r_lastRaddr <= '0;
      end else begin
         r_lenErr <= w_reject;
         if (w_accept) begin
            r_da     <= bus.tx_da;
            r_sa     <= {1'b0, bus.rack_id, bus.slot_id};
            r_fc     <= bus.tx_fc;
            r_mode   <= bus.tx_mode;
            r_addr   <= bus.tx_addr;
            r_plen   <= bus.tx_plen;
            r_txLen  <= 11'(HDR_LEN) + bus.tx_plen;
            r_hdrIdx <= '0;
            r_payCnt <= '0;
         end
         if (r_state == HDR) r_hdrIdx <= r_hdrIdx + 3'd1;
         if (r_state == PAY) r_payCnt <= r_payCnt + 11'd1;
         if (w_wren) begin
            r_lastWaddr <= w_waddr;
            r_lastWdata <= w_wdata;
         end
         if (w_rden) r_lastRaddr <= w_raddr;
      end
   end

   assign bus.tx_buf_wren  = w_wren;
   assign bus.tx_buf_waddr = w_waddr;
   assign bus.tx_buf_wdata = w_wdata;
   assign bus.src_rden     = w_rden;
   assign bus.src_raddr    = w_raddr;
   assign bus.tx_ack       = (r_state == HDR) && (r_hdrIdx == 3'd0);
   assign bus.len_err      = r_lenErr;
   assign bus.tx_start     = (r_state == START);
   assign bus.tx_len       = r_txLen;
   assign bus.tx_busy      = (r_state != IDLE);

endmodule
